bullet_slot_scheduler: RTL and testbench

Allocates the shared pool of bullet slots between Tank1 and Tank2. It arbitrates simultaneous fire requests and tracks a per-slot lifetime and a per-tank cooldown in frames. It drives the is_bulletN_active flags consumed by the colour mapper and bullet motion logic. It sits between the keyboard/tank control logic and the bullet datapath.

---
 rtl/tank_pkg.sv | 16 +
 rtl/bullet_slot.sv | 58 +++++
 rtl/bullet_slot_scheduler.sv | 169 ++++++++++++++++
 tb/tb_bullet_slot_scheduler.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types and defaults for the tank bullet slot scheduler.
// Slot owner encoding and pool sizing live here.
package tank_pkg;
  typedef enum logic {
    TANK1 = 1'b0,
    TANK2 = 1'b1
  } owner_t;

  localparam int DEF_NUM_SLOTS       = 3;
  localparam int DEF_TW              = 9;
  localparam int DEF_LIFETIME_FRAMES = 300;
  localparam int DEF_COOLDOWN_FRAMES = 15;
  localparam int DEF_MAX_PER_TANK    = 2;

  typedef logic [$clog2(DEF_NUM_SLOTS)-1:0] slot_idx_t;
endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: live flag, owning tank and frame lifetime counter.
// Clear beats load; load beats kill/expiry; kill and expiry merge.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int TW              = DEF_TW,
  parameter int LIFETIME_FRAMES = DEF_LIFETIME_FRAMES
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clear_i,
  input  logic   load_i,
  input  owner_t load_owner_i,
  input  logic   kill_i,
  input  logic   frame_tick_i,
  output logic   active_o,
  output owner_t owner_o
);
  logic          active_q, active_d;
  owner_t        owner_q, owner_d;
  logic [TW-1:0] life_q, life_d;

  always_comb begin
    active_d = active_q;
    owner_d  = owner_q;
    life_d   = life_q;
    if (clear_i) begin
      active_d = 1'b0;
      life_d   = '0;
    end else if (load_i) begin
      active_d = 1'b1;
      owner_d  = load_owner_i;
      life_d   = TW'(LIFETIME_FRAMES);
    end else if (active_q) begin
      if (kill_i || (frame_tick_i && life_q == TW'(1))) begin
        active_d = 1'b0;
        life_d   = '0;
      end else if (frame_tick_i) begin
        life_d = life_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      owner_q  <= TANK1;
      life_q   <= '0;
    end else begin
      active_q <= active_d;
      owner_q  <= owner_d;
      life_q   <= life_d;
    end
  end

  assign active_o = active_q;
  assign owner_o  = owner_q;
endmodule

// File: rtl/bullet_slot_scheduler.sv
// Shares the bullet slot pool between two tanks: arbitration,
// round-robin tie-break, per-tank cooldown and active counts.
module bullet_slot_scheduler
  import tank_pkg::*;
#(
  parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
  parameter int LIFETIME_FRAMES = DEF_LIFETIME_FRAMES,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int MAX_PER_TANK    = DEF_MAX_PER_TANK,
  parameter int TW              = DEF_TW,
  localparam int SW             = $clog2(NUM_SLOTS)
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 game_enable,
  input  logic                 frame_tick,
  input  logic                 fire_req1,
  input  logic                 fire_req2,
  input  logic [NUM_SLOTS-1:0] kill,
  output logic [NUM_SLOTS-1:0] bullet_active,
  output logic [NUM_SLOTS-1:0] bullet_owner,
  output logic                 grant1,
  output logic                 grant2,
  output logic [SW-1:0]        grant_slot1,
  output logic [SW-1:0]        grant_slot2,
  output logic                 deny1,
  output logic                 deny2,
  output logic [1:0]           count1,
  output logic [1:0]           count2
);
  localparam logic [1:0] MAXC = 2'(MAX_PER_TANK);

  owner_t         owner_w [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] load;
  owner_t         load_owner [NUM_SLOTS];

  logic [SW-1:0]  f0, f1, s1, s2;
  logic           f0_ok, f1_ok, e1, e2, g1, g2;
  owner_t         rr_q, rr_d;
  logic [TW-1:0]  cd1_q, cd1_d, cd2_q, cd2_d;
  logic           g1_q, g2_q, d1_q, d2_q;
  logic [SW-1:0]  s1_q, s2_q;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign load[i] = (g1 && s1 == SW'(i)) || (g2 && s2 == SW'(i));
    assign load_owner[i] = (g2 && s2 == SW'(i)) ? TANK2 : TANK1;
    assign bullet_owner[i] = owner_w[i];

    bullet_slot #(
      .TW             (TW),
      .LIFETIME_FRAMES(LIFETIME_FRAMES)
    ) u_slot (
      .clk_i       (CLK),
      .rst_i       (Reset),
      .clear_i     (!game_enable),
      .load_i      (load[i]),
      .load_owner_i(load_owner[i]),
      .kill_i      (kill[i]),
      .frame_tick_i(frame_tick),
      .active_o    (bullet_active[i]),
      .owner_o     (owner_w[i])
    );
  end

  always_comb begin
    count1 = '0;
    count2 = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bullet_active[i] && !bullet_owner[i]) count1 = count1 + 2'd1;
      if (bullet_active[i] && bullet_owner[i])  count2 = count2 + 2'd1;
    end
  end

  // Free means inactive at the start of the cycle, so killed slots wait.
  always_comb begin
    f0    = '0;
    f1    = '0;
    f0_ok = 1'b0;
    f1_ok = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!bullet_active[i]) begin
        if (!f0_ok) begin
          f0    = SW'(i);
          f0_ok = 1'b1;
        end else if (!f1_ok) begin
          f1    = SW'(i);
          f1_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    e1   = fire_req1 && game_enable && cd1_q == '0 && count1 < MAXC && f0_ok;
    e2   = fire_req2 && game_enable && cd2_q == '0 && count2 < MAXC && f0_ok;
    g1   = 1'b0;
    g2   = 1'b0;
    s1   = '0;
    s2   = '0;
    rr_d = rr_q;
    if (e1 && e2) begin
      if (f1_ok) begin
        g1 = 1'b1;
        g2 = 1'b1;
        s1 = (rr_q == TANK1) ? f0 : f1;
        s2 = (rr_q == TANK1) ? f1 : f0;
      end else if (rr_q == TANK1) begin
        g1   = 1'b1;
        s1   = f0;
        rr_d = TANK2;
      end else begin
        g2   = 1'b1;
        s2   = f0;
        rr_d = TANK1;
      end
    end else if (e1) begin
      g1 = 1'b1;
      s1 = f0;
    end else if (e2) begin
      g2 = 1'b1;
      s2 = f0;
    end
  end

  always_comb begin
    cd1_d = cd1_q;
    cd2_d = cd2_q;
    if (!game_enable) begin
      cd1_d = '0;
      cd2_d = '0;
    end else begin
      if (g1) cd1_d = TW'(COOLDOWN_FRAMES);
      else if (frame_tick && cd1_q != '0) cd1_d = cd1_q - TW'(1);
      if (g2) cd2_d = TW'(COOLDOWN_FRAMES);
      else if (frame_tick && cd2_q != '0) cd2_d = cd2_q - TW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rr_q  <= TANK1;
      cd1_q <= '0;
      cd2_q <= '0;
      g1_q  <= 1'b0;
      g2_q  <= 1'b0;
      d1_q  <= 1'b0;
      d2_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      rr_q  <= rr_d;
      cd1_q <= cd1_d;
      cd2_q <= cd2_d;
      g1_q  <= g1;
      g2_q  <= g2;
      d1_q  <= fire_req1 && !g1;
      d2_q  <= fire_req2 && !g2;
      s1_q  <= s1;
      s2_q  <= s2;
    end
  end

  assign grant1      = g1_q;
  assign grant2      = g2_q;
  assign deny1       = d1_q;
  assign deny2       = d2_q;
  assign grant_slot1 = s1_q;
  assign grant_slot2 = s2_q;
endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// Vector-table bench for the bullet slot scheduler: default build
// plus a short-lifetime build sharing the same stimulus.
module tb_bullet_slot_scheduler;
  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       game_enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fire_req1 = 1'b0;
  logic       fire_req2 = 1'b0;
  logic [2:0] kill = '0;

  logic [2:0] a_act, a_own, b_act, b_own;
  logic       a_g1, a_g2, a_d1, a_d2, b_g1, b_g2, b_d1, b_d2;
  logic [1:0] a_s1, a_s2, a_c1, a_c2, b_s1, b_s2, b_c1, b_c2;

  always #5 CLK = ~CLK;

  bullet_slot_scheduler u_a (
    .CLK(CLK), .Reset(Reset), .game_enable(game_enable),
    .frame_tick(frame_tick), .fire_req1(fire_req1),
    .fire_req2(fire_req2), .kill(kill),
    .bullet_active(a_act), .bullet_owner(a_own),
    .grant1(a_g1), .grant2(a_g2),
    .grant_slot1(a_s1), .grant_slot2(a_s2),
    .deny1(a_d1), .deny2(a_d2),
    .count1(a_c1), .count2(a_c2)
  );

  bullet_slot_scheduler #(
    .LIFETIME_FRAMES(4),
    .COOLDOWN_FRAMES(2)
  ) u_b (
    .CLK(CLK), .Reset(Reset), .game_enable(game_enable),
    .frame_tick(frame_tick), .fire_req1(fire_req1),
    .fire_req2(fire_req2), .kill(kill),
    .bullet_active(b_act), .bullet_owner(b_own),
    .grant1(b_g1), .grant2(b_g2),
    .grant_slot1(b_s1), .grant_slot2(b_s2),
    .deny1(b_d1), .deny2(b_d2),
    .count1(b_c1), .count2(b_c2)
  );

  typedef struct {
    logic       rst, en, tick, r1, r2;
    logic [2:0] kill;
    logic       g1, g2;
    logic [1:0] s1, s2;
    logic       d1, d2;
    logic [2:0] act, own;
    logic [1:0] c1, c2;
  } vec_t;

  vec_t exp_q[$];
  vec_t ta[$];
  vec_t tb2[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t v(
    input logic rst, en, tick, r1, r2, input logic [2:0] k,
    input logic g1, g2, input logic [1:0] s1, s2,
    input logic d1, d2, input logic [2:0] act, own,
    input logic [1:0] c1, c2);
    vec_t t;
    t.rst = rst; t.en = en; t.tick = tick; t.r1 = r1; t.r2 = r2;
    t.kill = k; t.g1 = g1; t.g2 = g2; t.s1 = s1; t.s2 = s2;
    t.d1 = d1; t.d2 = d2; t.act = act; t.own = own;
    t.c1 = c1; t.c2 = c2;
    return t;
  endfunction

  task automatic apply(input vec_t t, input bit sel, input int idx);
    vec_t        e;
    logic [17:0] got, want;
    @(negedge CLK);
    Reset       = t.rst;
    game_enable = t.en;
    frame_tick  = t.tick;
    fire_req1   = t.r1;
    fire_req2   = t.r2;
    kill        = t.kill;
    exp_q.push_back(t);
    @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL dut%0d vec%0d: scoreboard empty", sel, idx);
    end else begin
      e = exp_q.pop_front();
      want = {e.g1, e.g2, e.s1, e.s2, e.d1, e.d2,
              e.act, e.own, e.c1, e.c2};
      if (sel)
        got = {b_g1, b_g2, b_s1 & {2{b_g1}}, b_s2 & {2{b_g2}},
               b_d1, b_d2, b_act, b_own, b_c1, b_c2};
      else
        got = {a_g1, a_g2, a_s1 & {2{a_g1}}, a_s2 & {2{a_g2}},
               a_d1, a_d2, a_act, a_own, a_c1, a_c2};
      if (got !== want) begin
        n_bad++;
        $display("FAIL dut%0d vec%0d {g1,g2,s1,s2,d1,d2,act,own,c1,c2}: got %b want %b",
                 sel, idx, got, want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Default build: single shots, cooldown, per-tank cap, disable.
    ta.push_back(v(1,0,0,0,0,0, 0,0,0,0,0,0, 3'b000,3'b000,0,0));
    ta.push_back(v(0,1,0,0,0,0, 0,0,0,0,0,0, 3'b000,3'b000,0,0));
    ta.push_back(v(0,1,0,1,0,0, 1,0,0,0,0,0, 3'b001,3'b000,1,0));
    ta.push_back(v(0,1,0,1,0,0, 0,0,0,0,1,0, 3'b001,3'b000,1,0));
    for (int k = 0; k < 15; k++)
      ta.push_back(v(0,1,1,0,0,0, 0,0,0,0,0,0, 3'b001,3'b000,1,0));
    ta.push_back(v(0,1,0,1,0,0, 1,0,1,0,0,0, 3'b011,3'b000,2,0));
    for (int k = 0; k < 15; k++)
      ta.push_back(v(0,1,1,0,0,0, 0,0,0,0,0,0, 3'b011,3'b000,2,0));
    ta.push_back(v(0,1,0,1,1,0, 0,1,0,2,1,0, 3'b111,3'b100,2,1));
    ta.push_back(v(0,0,0,0,1,0, 0,0,0,0,0,1, 3'b000,3'b100,0,0));
    ta.push_back(v(0,1,0,0,0,0, 0,0,0,0,0,0, 3'b000,3'b100,0,0));
    // Dual requests, round-robin flip, kill-cycle non-reuse.
    ta.push_back(v(1,0,0,0,0,0, 0,0,0,0,0,0, 3'b000,3'b000,0,0));
    ta.push_back(v(0,1,0,1,1,0, 1,1,0,1,0,0, 3'b011,3'b010,1,1));
    for (int k = 0; k < 15; k++)
      ta.push_back(v(0,1,1,0,0,0, 0,0,0,0,0,0, 3'b011,3'b010,1,1));
    ta.push_back(v(0,1,0,1,1,0, 1,0,2,0,0,1, 3'b111,3'b010,2,1));
    ta.push_back(v(0,1,0,0,1,3'b001, 0,0,0,0,0,1, 3'b110,3'b010,1,1));
    for (int k = 0; k < 15; k++)
      ta.push_back(v(0,1,1,0,0,0, 0,0,0,0,0,0, 3'b110,3'b010,1,1));
    ta.push_back(v(0,1,0,1,1,0, 0,1,0,0,1,0, 3'b111,3'b011,1,2));
    ta.push_back(v(0,0,0,0,1,0, 0,0,0,0,0,1, 3'b000,3'b011,0,0));

    // Lifetime 4, cooldown 2: expiry, kill, kill+expiry overlap.
    tb2.push_back(v(1,0,0,0,0,0, 0,0,0,0,0,0, 3'b000,3'b000,0,0));
    tb2.push_back(v(0,1,1,1,0,0, 1,0,0,0,0,0, 3'b001,3'b000,1,0));
    for (int k = 0; k < 3; k++)
      tb2.push_back(v(0,1,1,0,0,0, 0,0,0,0,0,0, 3'b001,3'b000,1,0));
    tb2.push_back(v(0,1,1,0,0,0, 0,0,0,0,0,0, 3'b000,3'b000,0,0));
    tb2.push_back(v(0,1,0,1,0,0, 1,0,0,0,0,0, 3'b001,3'b000,1,0));
    tb2.push_back(v(0,1,1,0,0,0, 0,0,0,0,0,0, 3'b001,3'b000,1,0));
    tb2.push_back(v(0,1,1,0,0,3'b001, 0,0,0,0,0,0, 3'b000,3'b000,0,0));
    tb2.push_back(v(0,1,1,0,0,0, 0,0,0,0,0,0, 3'b000,3'b000,0,0));
    tb2.push_back(v(0,1,0,1,0,0, 1,0,0,0,0,0, 3'b001,3'b000,1,0));
    for (int k = 0; k < 3; k++)
      tb2.push_back(v(0,1,1,0,0,0, 0,0,0,0,0,0, 3'b001,3'b000,1,0));
    tb2.push_back(v(0,1,1,0,0,3'b001, 0,0,0,0,0,0, 3'b000,3'b000,0,0));
    tb2.push_back(v(0,1,0,1,0,3'b001, 1,0,0,0,0,0, 3'b001,3'b000,1,0));
    tb2.push_back(v(0,1,0,0,0,0, 0,0,0,0,0,0, 3'b001,3'b000,1,0));

    foreach (ta[i])  apply(ta[i], 1'b0, i);
    foreach (tb2[i]) apply(tb2[i], 1'b1, i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
